// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_ctrl_pkg                                                  |
// | Purpose  : Shared types, constants and helpers for the pipeline hazard     |
// |            controller and its mult/div busy counter.                       |
// | Contents : state_t FSM encoding, REG_ZERO, default latency / timeout       |
// |            values, cnt_width() counter sizing helper.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO        = 5'd0;
   localparam int         MD_LATENCY_DEF  = 32;
   localparam int         MEM_TIMEOUT_DEF = 255;

   // Bits needed to hold the value n itself (counters load or reach n).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : md_busy_counter                                                  |
// | Purpose  : Tracks the multi-cycle mult/div unit. Loads LATENCY on start,   |
// |            counts down to zero and saturates there.                        |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            start_i - one-cycle launch pulse                                |
// |            busy_o  - result not yet valid (counter nonzero)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module md_busy_counter
   import hazard_ctrl_pkg::*;
#(
   parameter int LATENCY = MD_LATENCY_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   output logic busy_o
);

   localparam int                 CNT_W         = cnt_width(LATENCY);
   localparam logic [CNT_W-1:0]   c_LOAD_VAL    = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0]   c_ONE         = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = c_LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - c_ONE;
      end
   end

   // Async clear lets busy drop the moment reset asserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule : md_busy_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_ctrl                                                      |
// | Purpose  : Pipeline sequencing controller for the 5-stage MIPS core.       |
// |            Resolves load-use stalls, taken-branch flushes, mult/div        |
// |            structural stalls and data-memory wait freezes.                 |
// | Inputs   : ID/EX register fields and flags, branch outcome, MEM access     |
// |            and data-memory acknowledge.                                    |
// | Outputs  : PC / IF/ID / ID/EX / EX/MEM / MEM/WB enables, flushes and       |
// |            bubbles; md_start, md_busy, sticky mem_timeout.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MD_LATENCY  = MD_LATENCY_DEF,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ID_RegRs_IN,
   input  logic [4:0] ID_RegRt_IN,
   input  logic       ID_usesRt_IN,
   input  logic       ID_isMulDiv_IN,
   input  logic       ID_readsHiLo_IN,
   input  logic [4:0] ID_EX_RegRt_IN,
   input  logic       ID_EX_memRead_IN,
   input  logic       ID_EX_mulDiv_IN,
   input  logic       EX_branchTaken_IN,
   input  logic       MEM_access_IN,
   input  logic       MEM_ready_IN,
   output logic       PC_write,
   output logic       IF_ID_write,
   output logic       IF_ID_flush,
   output logic       ID_EX_bubble,
   output logic       ID_EX_write,
   output logic       EX_MEM_write,
   output logic       MEM_WB_bubble,
   output logic       md_start,
   output logic       md_busy,
   output logic       mem_timeout
);

   localparam int               WCNT_W        = cnt_width(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] c_TIMEOUT_VAL = WCNT_W'(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] c_WCNT_ONE    = WCNT_W'(1);

   state_t            state_q;
   state_t            state_d;
   logic [WCNT_W-1:0] wcnt_q;
   logic [WCNT_W-1:0] wcnt_d;
   logic              timeout_q;
   logic              timeout_d;

   logic              w_freeze;
   logic              w_load_use;
   logic              w_md_hazard;
   logic              w_md_busy;
   logic              w_md_start;

   // ------------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------------
   // In RUN the freeze is raised in the same cycle the access misses, so a
   // miss costs exactly one cycle per cycle of ready staying low.
   assign w_freeze = (state_q == RUN) ? (MEM_access_IN & ~MEM_ready_IN)
                                      : ~MEM_ready_IN;

   // $zero is never a real destination, so a load to it cannot create a hazard.
   assign w_load_use = ID_EX_memRead_IN
                     & (ID_EX_RegRt_IN != REG_ZERO)
                     & ((ID_EX_RegRt_IN == ID_RegRs_IN)
                        | (ID_usesRt_IN & (ID_EX_RegRt_IN == ID_RegRt_IN)));

   assign w_md_hazard = w_md_busy & (ID_readsHiLo_IN | ID_isMulDiv_IN);

   // Gated with rst_n so the launch pulse is forced low during reset.
   assign w_md_start  = ID_EX_mulDiv_IN & ~w_freeze & ~w_md_busy & rst_n;

   md_busy_counter #(
      .LATENCY (MD_LATENCY)
   ) u_md_busy_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (w_md_start),
      .busy_o  (w_md_busy)
   );

   // ------------------------------------------------------------------------
   // Memory-wait FSM and timeout watchdog
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      wcnt_d    = '0;
      timeout_d = timeout_q;
      case (state_q)
         RUN: begin
            if (MEM_access_IN && !MEM_ready_IN) begin
               state_d = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (MEM_ready_IN) begin
               state_d = RUN;
            end
            // Saturate at the threshold; the flag is sticky so nothing beyond
            // it needs to be counted.
            wcnt_d = (wcnt_q == c_TIMEOUT_VAL) ? wcnt_q : (wcnt_q + c_WCNT_ONE);
            if (wcnt_d == c_TIMEOUT_VAL) begin
               timeout_d = 1'b1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         timeout_q <= timeout_d;
      end
   end

   // ------------------------------------------------------------------------
   // Pipeline control outputs, fixed priority
   // ------------------------------------------------------------------------
   always_comb begin
      PC_write      = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_bubble  = 1'b0;
      ID_EX_write   = 1'b1;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      if (!rst_n) begin
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_bubble  = 1'b1;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         MEM_WB_bubble = 1'b1;
      end else if (w_freeze) begin
         // EX is held, so a taken branch stays put and is re-resolved after
         // release; its flush must not fire now.
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_write   = 1'b0;
         EX_MEM_write  = 1'b0;
         MEM_WB_bubble = 1'b1;
      end else if (EX_branchTaken_IN) begin
         // The stalled ID instruction is on the wrong path anyway.
         IF_ID_flush   = 1'b1;
         ID_EX_bubble  = 1'b1;
      end else if (w_md_hazard || w_load_use) begin
         PC_write      = 1'b0;
         IF_ID_write   = 1'b0;
         ID_EX_bubble  = 1'b1;
      end
   end

   assign md_start    = w_md_start;
   assign md_busy     = w_md_busy;
   assign mem_timeout = timeout_q;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_hazard_ctrl                                                   |
// | Purpose  : Directed self-checking bench for hazard_ctrl with               |
// |            MD_LATENCY=4 and MEM_TIMEOUT=8.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] ID_RegRs_IN, ID_RegRt_IN, ID_EX_RegRt_IN;
   logic       ID_usesRt_IN, ID_isMulDiv_IN, ID_readsHiLo_IN;
   logic       ID_EX_memRead_IN, ID_EX_mulDiv_IN, EX_branchTaken_IN;
   logic       MEM_access_IN, MEM_ready_IN;
   logic       PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write;
   logic       EX_MEM_write, MEM_WB_bubble, md_start, md_busy, mem_timeout;

   int n_chk  = 0;
   int n_fail = 0;

   // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
   //  ID_EX_write, EX_MEM_write, MEM_WB_bubble, md_start}
   logic [7:0] ctl;
   assign ctl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble,
                 ID_EX_write, EX_MEM_write, MEM_WB_bubble, md_start};

   localparam logic [7:0] E_NORMAL = 8'b1100_1100;
   localparam logic [7:0] E_START  = 8'b1100_1101;
   localparam logic [7:0] E_RESET  = 8'b0011_0010;
   localparam logic [7:0] E_STALL  = 8'b0001_1100;
   localparam logic [7:0] E_BRANCH = 8'b1111_1100;
   localparam logic [7:0] E_FREEZE = 8'b0000_0010;

   hazard_ctrl #(
      .MD_LATENCY  (4),
      .MEM_TIMEOUT (8)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ID_RegRs_IN       (ID_RegRs_IN),
      .ID_RegRt_IN       (ID_RegRt_IN),
      .ID_usesRt_IN      (ID_usesRt_IN),
      .ID_isMulDiv_IN    (ID_isMulDiv_IN),
      .ID_readsHiLo_IN   (ID_readsHiLo_IN),
      .ID_EX_RegRt_IN    (ID_EX_RegRt_IN),
      .ID_EX_memRead_IN  (ID_EX_memRead_IN),
      .ID_EX_mulDiv_IN   (ID_EX_mulDiv_IN),
      .EX_branchTaken_IN (EX_branchTaken_IN),
      .MEM_access_IN     (MEM_access_IN),
      .MEM_ready_IN      (MEM_ready_IN),
      .PC_write          (PC_write),
      .IF_ID_write       (IF_ID_write),
      .IF_ID_flush       (IF_ID_flush),
      .ID_EX_bubble      (ID_EX_bubble),
      .ID_EX_write       (ID_EX_write),
      .EX_MEM_write      (EX_MEM_write),
      .MEM_WB_bubble     (MEM_WB_bubble),
      .md_start          (md_start),
      .md_busy           (md_busy),
      .mem_timeout       (mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change and are checked at the falling edge, one cycle per call.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ID_RegRs_IN       = 5'd0;
      ID_RegRt_IN       = 5'd0;
      ID_EX_RegRt_IN    = 5'd0;
      ID_usesRt_IN      = 1'b0;
      ID_isMulDiv_IN    = 1'b0;
      ID_readsHiLo_IN   = 1'b0;
      ID_EX_memRead_IN  = 1'b0;
      ID_EX_mulDiv_IN   = 1'b0;
      EX_branchTaken_IN = 1'b0;
      MEM_access_IN     = 1'b0;
      MEM_ready_IN      = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();

      // Reset values
      @(negedge clk);
      #1;
      chk("reset_ctl",     ctl,                E_RESET);
      chk("reset_busy",    {7'd0, md_busy},    8'd0);
      chk("reset_timeout", {7'd0, mem_timeout}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #1;
      chk("idle_ctl", ctl, E_NORMAL);

      // Load-use on rs: one stall cycle, clears once the load leaves EX
      ID_EX_memRead_IN = 1'b1; ID_EX_RegRt_IN = 5'd5; ID_RegRs_IN = 5'd5;
      #1;
      chk("loaduse_rs", ctl, E_STALL);
      tick();
      ID_EX_memRead_IN = 1'b0; ID_EX_RegRt_IN = 5'd0;
      #1;
      chk("loaduse_release", ctl, E_NORMAL);

      // Load into $zero never stalls
      ID_EX_memRead_IN = 1'b1; ID_EX_RegRt_IN = 5'd0; ID_RegRs_IN = 5'd0;
      #1;
      chk("loaduse_r0", ctl, E_NORMAL);

      // Load-use via rt, only when rt is a source
      ID_EX_RegRt_IN = 5'd7; ID_RegRt_IN = 5'd7; ID_RegRs_IN = 5'd3; ID_usesRt_IN = 1'b1;
      #1;
      chk("loaduse_rt", ctl, E_STALL);
      ID_usesRt_IN = 1'b0;
      #1;
      chk("loaduse_rt_unused", ctl, E_NORMAL);

      // Taken branch beats load-use
      ID_usesRt_IN = 1'b1; EX_branchTaken_IN = 1'b1;
      #1;
      chk("branch_over_loaduse", ctl, E_BRANCH);
      tick();
      idle_inputs();

      // Mult/div: start pulse, 4 busy cycles stalling mfhi, advance on 5th
      ID_EX_mulDiv_IN = 1'b1;
      #1;
      chk("md_start",      ctl,             E_START);
      chk("md_busy_pre",   {7'd0, md_busy}, 8'd0);
      tick();
      ID_EX_mulDiv_IN = 1'b0; ID_readsHiLo_IN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("md_busy_%0d", i),  {7'd0, md_busy}, 8'd1);
         chk($sformatf("md_stall_%0d", i), ctl,             E_STALL);
         tick();
      end
      #1;
      chk("md_busy_done", {7'd0, md_busy}, 8'd0);
      chk("mfhi_advance", ctl,             E_NORMAL);
      idle_inputs();

      // Memory wait: ready low 3 cycles with a pending branch, flush after release
      MEM_access_IN = 1'b1; MEM_ready_IN = 1'b0; EX_branchTaken_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mem_freeze_%0d", i), ctl, E_FREEZE);
         tick();
      end
      MEM_ready_IN = 1'b1;
      #1;
      chk("mem_release_branch", ctl, E_BRANCH);
      tick();
      idle_inputs();
      #1;
      chk("mem_back_run",       ctl,                 E_NORMAL);
      chk("mem_no_timeout",     {7'd0, mem_timeout}, 8'd0);

      // Timeout: RUN miss cycle plus 8 MEM_WAIT cycles, then flag sets
      MEM_access_IN = 1'b1; MEM_ready_IN = 1'b0;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk($sformatf("timeout_low_%0d", i), {7'd0, mem_timeout}, 8'd0);
         tick();
      end
      #1;
      chk("timeout_set", {7'd0, mem_timeout}, 8'd1);
      MEM_ready_IN = 1'b1;
      tick();
      MEM_access_IN = 1'b0;
      tick();
      tick();
      #1;
      chk("timeout_sticky",     {7'd0, mem_timeout}, 8'd1);
      chk("timeout_run_normal", ctl,                 E_NORMAL);
      idle_inputs();

      // Reset mid-operation: md busy and FSM in MEM_WAIT
      ID_EX_mulDiv_IN = 1'b1;
      tick();
      ID_EX_mulDiv_IN = 1'b0; MEM_access_IN = 1'b1; MEM_ready_IN = 1'b0;
      tick();
      MEM_access_IN = 1'b0;
      #1;
      chk("midop_busy",   {7'd0, md_busy}, 8'd1);
      chk("midop_freeze", ctl,             E_FREEZE);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midop_rst_ctl",     ctl,                 E_RESET);
      chk("midop_rst_busy",    {7'd0, md_busy},     8'd0);
      chk("midop_rst_timeout", {7'd0, mem_timeout}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      // ready low with no access: RUN gives normal flow, MEM_WAIT would freeze
      #1;
      chk("post_rst_run",  ctl,             E_NORMAL);
      chk("post_rst_busy", {7'd0, md_busy}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Safety net against a hung run
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core, sitting beside the forwarding unit. It resolves the hazards forwarding cannot cover:
- load-use stalls;
- taken-branch flushes;
- structural stalls while the multi-cycle multiply/divide unit is busy;
- full-pipeline freezes while data memory has not acknowledged.

It drives the write-enables, flushes and bubbles of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and issues the mult/div start pulse.

## Interface
- MD_LATENCY, 32: cycles the mult/div unit needs after md_start (≥1).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before mem_timeout sets (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ID_RegRs_IN  in  5  rs of instruction in ID.
- ID_RegRt_IN  in  5  rt of instruction in ID.
- ID_usesRt_IN  in  1  ID instruction reads rt as a source.
- ID_isMulDiv_IN  in  1  ID instruction is mult/multu/div/divu.
- ID_readsHiLo_IN  in  1  ID instruction is mfhi/mflo.
- ID_EX_RegRt_IN  in  5  rt (load destination) of instruction in EX.
- ID_EX_memRead_IN  in  1  EX instruction is a load.
- ID_EX_mulDiv_IN  in  1  EX instruction is mult/div.
- EX_branchTaken_IN  in  1  branch/jump in EX resolved taken.
- MEM_access_IN  in  1  MEM-stage instruction is a load/store.
- MEM_ready_IN  in  1  data memory acknowledge.
- PC_write  out  1  PC load enable.
- IF_ID_write  out  1  IF/ID load enable.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_bubble  out  1  ID/EX loads control-zero bubble.
- ID_EX_write  out  1  ID/EX load enable.
- EX_MEM_write  out  1  EX/MEM load enable.
- MEM_WB_bubble  out  1  MEM/WB loads control-zero bubble.
- md_start  out  1  one-cycle mult/div launch.
- md_busy  out  1  mult/div result not yet valid.
- mem_timeout  out  1  sticky memory-timeout flag.

## Operation
- The FSM has two states: RUN and MEM_WAIT.
  - RUN → MEM_WAIT when MEM_access_IN & !MEM_ready_IN.
  - MEM_WAIT → RUN when MEM_ready_IN.
- freeze = (RUN & MEM_access_IN & !MEM_ready_IN) | (MEM_WAIT & !MEM_ready_IN).
- Outputs are combinational, evaluated in fixed priority. Any output not listed for the active case holds its default: all write-enables 1, all flush/bubble 0.
  1. **freeze:** PC_write, IF_ID_write, ID_EX_write and EX_MEM_write are 0; MEM_WB_bubble is 1; md_start is 0; branch flush is suppressed. EX is held, so the branch re-evaluates after release.
  2. **EX_branchTaken_IN:** IF_ID_flush and ID_EX_bubble are 1; PC_write is 1. This overrides cases 3 and 4.
  3. **MD hazard, md_busy & (ID_readsHiLo_IN | ID_isMulDiv_IN):** PC_write and IF_ID_write are 0; ID_EX_bubble is 1.
  4. **Load-use, ID_EX_memRead_IN & ID_EX_RegRt_IN≠0 & (ID_EX_RegRt_IN==ID_RegRs_IN | (ID_usesRt_IN & ID_EX_RegRt_IN==ID_RegRt_IN)):** same outputs as case 3.
- md_start = ID_EX_mulDiv_IN & !freeze & !md_busy.
- The mult/div counter loads MD_LATENCY on md_start, decrements each cycle while nonzero (including during freeze), and saturates at 0. md_busy = (cnt≠0).
- The wait counter clears in RUN and increments in MEM_WAIT (saturating). Reaching MEM_TIMEOUT sets mem_timeout, which stays set until reset. The FSM does not abort.

## Timing
- Reset (rst_n low, asynchronous):
  - state RUN; both counters 0; mem_timeout 0.
  - Outputs forced: PC_write, IF_ID_write, ID_EX_write and EX_MEM_write are 0; IF_ID_flush, ID_EX_bubble and MEM_WB_bubble are 1; md_start and md_busy are 0.
- Normal operation begins on the first rising edge after deassertion.
- A load-use stall lasts exactly 1 cycle; the hazard clears once the load leaves EX.
- md_busy rises the cycle after md_start and stays high exactly MD_LATENCY cycles. A stalled mfhi in ID advances on the first cycle md_busy is 0.
- MEM_ready_IN together with MEM_access_IN in RUN costs no cycles. Each cycle MEM_ready_IN stays low adds one freeze cycle.
- Reset mid-operation: the counter is discarded and the FSM returns to RUN immediately. md_busy drops asynchronously.

## Structure
- Package hazard_ctrl_pkg holds:
  - enum state_t {RUN, MEM_WAIT};
  - REG_ZERO = 5'd0;
  - defaults for MD_LATENCY and MEM_TIMEOUT;
  - function cnt_width(n), used to size both counters.
- One sub-module, md_busy_counter: the load/decrement/saturate counter producing md_busy. The FSM and priority logic stay in hazard_ctrl.

## Test plan
- **Load-use:** EX lw rt=5 (memRead=1), ID rs=5 → one cycle with PC_write=0, IF_ID_write=0, ID_EX_bubble=1. The same setup with rt=0 → no stall.
- **Branch vs load-use:** EX_branchTaken=1 while the load-use condition is also true → IF_ID_flush=1, ID_EX_bubble=1, PC_write=1.
- **Mult/div:** MD_LATENCY=4, EX mult → md_start for 1 cycle, md_busy high for 4 cycles. mfhi in ID stalls during those 4 cycles and advances on the 5th.
- **Memory wait:** MEM_access=1, MEM_ready low for 3 cycles → 3 freeze cycles with MEM_WB_bubble=1. A pending branch flush fires after release.
- **Timeout:** MEM_TIMEOUT=8, ready held low → mem_timeout rises after 8 MEM_WAIT cycles and stays 1 after ready returns, until rst_n.
- **Reset mid-op:** rst_n pulsed low while md_busy is high and the FSM is in MEM_WAIT → outputs take their reset values immediately; after release, state is RUN and md_busy is 0.
